// File: rtl/acorn128_pkg.sv
// Shared definitions for the ACORN-128 phase sequencer.
// Contents: FSM state encoding, phase step counts, and a helper that
// tells which states present a step to the core.
package acorn128_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_INIT,
        S_AD,
        S_AD_PAD,
        S_TEXT,
        S_TEXT_PAD,
        S_FINAL,
        S_DONE
    } state_t;

    localparam int INIT_STEPS  = 1792;
    localparam int PAD_STEPS   = 256;
    localparam int PAD_HALF    = 128;
    localparam int FINAL_STEPS = 768;
    localparam int TAG_START   = 640;
    localparam int K_W         = 11;

    function automatic logic is_step_state(input state_t s);
        return (s inside {S_INIT, S_AD, S_AD_PAD, S_TEXT, S_TEXT_PAD, S_FINAL});
    endfunction

endpackage

// File: rtl/acorn128_sequencer_if.sv
// Bundle of the sequencer's command, core-control and result signals.
// slave  : the sequencer side (takes commands and keystream, drives controls/results)
// master : the command/core side (drives commands and keystream, observes results)
interface acorn128_sequencer_if;
    logic         start_in;
    logic         encrypt_in;
    logic [127:0] key_in;
    logic [127:0] iv_in;
    logic [127:0] ad_in;
    logic [7:0]   ad_len_in;
    logic [127:0] text_in;
    logic [7:0]   text_len_in;
    logic         core_clear_out;
    logic         step_en_out;
    logic         core_ready_in;
    logic         m_bit_out;
    logic         ca_out;
    logic         cb_out;
    logic         ks_bit_in;
    logic [127:0] text_out;
    logic [127:0] tag_out;
    logic         busy_out;
    logic         done_out;

    modport slave (
        input  start_in, encrypt_in, key_in, iv_in, ad_in, ad_len_in,
               text_in, text_len_in, core_ready_in, ks_bit_in,
        output core_clear_out, step_en_out, m_bit_out, ca_out, cb_out,
               text_out, tag_out, busy_out, done_out
    );

    modport master (
        output start_in, encrypt_in, key_in, iv_in, ad_in, ad_len_in,
               text_in, text_len_in, core_ready_in, ks_bit_in,
        input  core_clear_out, step_en_out, m_bit_out, ca_out, cb_out,
               text_out, tag_out, busy_out, done_out
    );
endinterface

// File: rtl/acorn128_mbit_sel.sv
// Combinational selection of the per-step core controls (m, ca, cb).
// Ports: state/k locate the current step; key/iv/ad/text are the latched
// operands; encrypt selects the TEXT m source; ks_bit is the core's
// keystream bit for the current state. Outputs are 0 outside step states.
module acorn128_mbit_sel
    import acorn128_pkg::*;
(
    input  state_t         state,
    input  logic [K_W-1:0] k,
    input  logic [127:0]   key,
    input  logic [127:0]   iv,
    input  logic [127:0]   ad,
    input  logic [127:0]   text,
    input  logic           encrypt,
    input  logic           ks_bit,
    output logic           m_bit,
    output logic           ca,
    output logic           cb
);
    logic [6:0] idx;
    assign idx = k[6:0];

    always_comb begin
        m_bit = 1'b0;
        ca    = 1'b0;
        cb    = 1'b0;
        case (state)
            S_INIT: begin
                ca = 1'b1;
                cb = 1'b1;
                // Key, then IV, then the key repeated with bit 0 inverted once at k=256.
                if (k >= 11'd128 && k < 11'd256) m_bit = iv[idx];
                else                             m_bit = key[idx] ^ (k == 11'd256);
            end
            S_AD: begin
                ca    = 1'b1;
                cb    = 1'b1;
                m_bit = ad[idx];
            end
            S_AD_PAD, S_TEXT_PAD: begin
                m_bit = (k == '0);
                ca    = (k < 11'(PAD_HALF));
                cb    = (state == S_AD_PAD);
            end
            S_TEXT: begin
                ca = 1'b1;
                // Decrypt feeds the recovered plaintext back into the state.
                m_bit = encrypt ? text[idx] : (text[idx] ^ ks_bit);
            end
            S_FINAL: begin
                ca = 1'b1;
                cb = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/acorn128_sequencer.sv
// ACORN-128 phase sequencer: walks CLEAR/INIT/AD/AD_PAD/TEXT/TEXT_PAD/FINAL,
// presents one step per cycle to the state-update core, captures the
// text output bit by bit and assembles the tag from the FINAL keystream.
// Ports: clk, rst (sync, active low), bus (slave side of the command/core bundle).
module acorn128_sequencer
    import acorn128_pkg::*;
#(
    parameter int MAX_LEN = 128
) (
    input logic                 clk,
    input logic                 rst,
    acorn128_sequencer_if.slave bus
);
    state_t         state, state_nxt;
    logic [K_W-1:0] k;
    logic [K_W-1:0] phase_len;
    logic [127:0]   key_q, iv_q, ad_q, text_q, text_out_q, tag_q;
    logic [7:0]     ad_len_q, text_len_q;
    logic           enc_q;
    logic           step_en, step_acc, last_step;
    logic [6:0]     tag_idx;

    function automatic logic [7:0] clamp_len(input logic [7:0] len);
        if (int'(len) > MAX_LEN) return 8'(MAX_LEN);
        return len;
    endfunction

    always_comb begin
        phase_len = '0;
        case (state)
            S_INIT:               phase_len = 11'(INIT_STEPS);
            S_AD:                 phase_len = {3'b0, ad_len_q};
            S_AD_PAD, S_TEXT_PAD: phase_len = 11'(PAD_STEPS);
            S_TEXT:               phase_len = {3'b0, text_len_q};
            S_FINAL:              phase_len = 11'(FINAL_STEPS);
            default:              phase_len = '0;
        endcase
    end

    assign step_en   = is_step_state(state);
    assign step_acc  = step_en & bus.core_ready_in;
    assign last_step = step_acc && (k == phase_len - 11'd1);
    assign tag_idx   = 7'(k - 11'(TAG_START));

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (bus.start_in) state_nxt = S_CLEAR;
            S_CLEAR:    state_nxt = S_INIT;
            S_INIT:     if (last_step) state_nxt = (ad_len_q == '0) ? S_AD_PAD : S_AD;
            S_AD:       if (last_step) state_nxt = S_AD_PAD;
            S_AD_PAD:   if (last_step) state_nxt = (text_len_q == '0) ? S_TEXT_PAD : S_TEXT;
            S_TEXT:     if (last_step) state_nxt = S_TEXT_PAD;
            S_TEXT_PAD: if (last_step) state_nxt = S_FINAL;
            S_FINAL:    if (last_step) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            k          <= '0;
            key_q      <= '0;
            iv_q       <= '0;
            ad_q       <= '0;
            text_q     <= '0;
            ad_len_q   <= '0;
            text_len_q <= '0;
            enc_q      <= 1'b0;
            text_out_q <= '0;
            tag_q      <= '0;
        end else begin
            // Counter restarts on every phase change, advances only on accepted steps.
            if (state_nxt != state) k <= '0;
            else if (step_acc)      k <= k + 11'd1;

            if (state == S_IDLE && bus.start_in) begin
                key_q      <= bus.key_in;
                iv_q       <= bus.iv_in;
                ad_q       <= bus.ad_in;
                text_q     <= bus.text_in;
                ad_len_q   <= clamp_len(bus.ad_len_in);
                text_len_q <= clamp_len(bus.text_len_in);
                enc_q      <= bus.encrypt_in;
                text_out_q <= '0;
                tag_q      <= '0;
            end

            // Both directions output text ^ keystream.
            if (step_acc && state == S_TEXT)
                text_out_q[k[6:0]] <= text_q[k[6:0]] ^ bus.ks_bit_in;
            if (step_acc && state == S_FINAL && k >= 11'(TAG_START))
                tag_q[tag_idx] <= bus.ks_bit_in;
        end
    end

    acorn128_mbit_sel u_mbit_sel (
        .state   (state),
        .k       (k),
        .key     (key_q),
        .iv      (iv_q),
        .ad      (ad_q),
        .text    (text_q),
        .encrypt (enc_q),
        .ks_bit  (bus.ks_bit_in),
        .m_bit   (bus.m_bit_out),
        .ca      (bus.ca_out),
        .cb      (bus.cb_out)
    );

    assign bus.core_clear_out = (state == S_CLEAR);
    assign bus.step_en_out    = step_en;
    assign bus.busy_out       = (state != S_IDLE) && (state != S_DONE);
    assign bus.done_out       = (state == S_DONE);
    assign bus.text_out       = text_out_q;
    assign bus.tag_out        = tag_q;
endmodule

// File: tb/tb_acorn128_sequencer.sv
// Bench for acorn128_sequencer: an ACORN-style bit-serial core model answers
// the DUT's steps; a phase-level reference builds the expected control
// stream, text and tag from the operation rules.
module tb_acorn128_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acorn128_sequencer_if bus ();

    acorn128_sequencer #(.MAX_LEN(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         enc;
        logic [127:0] key, iv, ad, text;
        logic [7:0]   adl, tl;
    } req_t;

    typedef struct {
        logic       enc;
        logic [7:0] adl, tl;
        int         lat;
        int         steps;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0]   exp_q[$];
    logic [292:0] rs;
    logic [292:0] core_s;

    // ---------------- core model ----------------
    function automatic logic maj(input logic a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction
    function automatic logic ch(input logic a, b, c);
        return (a & b) ^ (~a & c);
    endfunction
    function automatic logic [292:0] mix(input logic [292:0] s);
        logic [292:0] t;
        t = s;
        t[289] = t[289] ^ t[235] ^ t[230];
        t[230] = t[230] ^ t[196] ^ t[193];
        t[193] = t[193] ^ t[160] ^ t[154];
        t[154] = t[154] ^ t[111] ^ t[107];
        t[107] = t[107] ^ t[66]  ^ t[61];
        t[61]  = t[61]  ^ t[23]  ^ t[0];
        return t;
    endfunction
    function automatic logic ks_of(input logic [292:0] s);
        logic [292:0] t;
        t = mix(s);
        return t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
    endfunction
    function automatic logic [292:0] core_step(input logic [292:0] s, input logic m, ca, cb);
        logic [292:0] t;
        logic ks, f;
        t  = mix(s);
        ks = ks_of(s);
        f  = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks) ^ m;
        return {f, t[292:1]};
    endfunction

    assign bus.ks_bit_in = ks_of(core_s);
    always @(posedge clk) begin
        if (!rst)                                   core_s <= '0;
        else if (bus.core_clear_out)                core_s <= '0;
        else if (bus.step_en_out && bus.core_ready_in)
            core_s <= core_step(core_s, bus.m_bit_out, bus.ca_out, bus.cb_out);
    end

    // ---------------- reference ----------------
    task automatic push(input logic m, ca, cb);
        exp_q.push_back({m, ca, cb});
        rs = core_step(rs, m, ca, cb);
    endtask

    task automatic ref_build(input req_t r, output logic [127:0] et, output logic [127:0] eg);
        int a, t;
        logic m, ks;
        a = (r.adl > 8'd128) ? 128 : int'(r.adl);
        t = (r.tl  > 8'd128) ? 128 : int'(r.tl);
        et = '0; eg = '0; rs = '0;
        exp_q.delete();
        for (int i = 0; i < 1792; i++) begin
            if (i < 128)       m = r.key[i];
            else if (i < 256)  m = r.iv[i-128];
            else if (i == 256) m = ~r.key[0];
            else               m = r.key[i%128];
            push(m, 1'b1, 1'b1);
        end
        for (int i = 0; i < a; i++) push(r.ad[i], 1'b1, 1'b1);
        for (int i = 0; i < 256; i++) push(i == 0, i < 128, 1'b1);
        for (int i = 0; i < t; i++) begin
            ks = ks_of(rs);
            et[i] = r.text[i] ^ ks;
            push(r.enc ? r.text[i] : et[i], 1'b1, 1'b0);
        end
        for (int i = 0; i < 256; i++) push(i == 0, i < 128, 1'b0);
        for (int i = 0; i < 768; i++) begin
            if (i >= 640) eg[i-640] = ks_of(rs);
            push(1'b0, 1'b1, 1'b1);
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic req_t mk_req(input logic enc, input logic [7:0] adl, tl);
        req_t r;
        r.enc  = enc;
        r.key  = {$urandom, $urandom, $urandom, $urandom};
        r.iv   = {$urandom, $urandom, $urandom, $urandom};
        r.ad   = {$urandom, $urandom, $urandom, $urandom};
        r.text = {$urandom, $urandom, $urandom, $urandom};
        r.adl  = adl;
        r.tl   = tl;
        return r;
    endfunction

    task automatic post_done(input string nm);
        @(posedge clk); #1;
        chk({nm, "_post"}, {125'd0, bus.done_out, bus.busy_out, bus.step_en_out}, '0);
    endtask

    task automatic run_case(input string nm, input req_t r, input int stall_pct,
                            input int exp_lat, input int exp_steps, input int poke_at,
                            input int rst_at, output logic [127:0] ct_o, output logic [127:0] tag_o);
        logic [127:0] et, eg;
        logic [2:0]   held, e, ctrl;
        logic         held_v, done_seen;
        int           cyc, nst, ndone;
        ref_build(r, et, eg);
        ct_o = et; tag_o = eg;
        bus.encrypt_in = r.enc; bus.key_in = r.key; bus.iv_in = r.iv; bus.ad_in = r.ad;
        bus.ad_len_in = r.adl; bus.text_in = r.text; bus.text_len_in = r.tl;
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        chk({nm, "_accept"}, {125'd0, bus.busy_out, bus.core_clear_out, bus.step_en_out}, 128'd6);
        cyc = 0; nst = 0; held_v = 1'b0; done_seen = 1'b0; held = '0;
        while (cyc < 12000) begin
            bus.core_ready_in = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            ctrl = {bus.m_bit_out, bus.ca_out, bus.cb_out};
            if (bus.step_en_out) begin
                if (held_v) begin
                    vectors++;
                    if (ctrl !== held) begin
                        miscompares++;
                        $display("FAIL %s stall_hold step %0d: got %b want %b", nm, nst, ctrl, held);
                    end
                end
                if (bus.core_ready_in) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL %s step %0d: got extra step want none", nm, nst);
                    end else begin
                        e = exp_q.pop_front();
                        if (ctrl !== e) begin
                            miscompares++;
                            $display("FAIL %s step %0d ctrl m/ca/cb: got %b want %b", nm, nst, ctrl, e);
                        end
                    end
                    nst++;
                end
                held_v = !bus.core_ready_in;
                held   = ctrl;
            end else held_v = 1'b0;
            @(posedge clk); #1;
            cyc++;
            bus.start_in = (cyc == poke_at);
            if (cyc == rst_at) begin
                bus.core_ready_in = 1'b1;
                rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
                chk({nm, "_rst_ctrl"}, {121'd0, bus.busy_out, bus.done_out, bus.step_en_out,
                    bus.core_clear_out, bus.m_bit_out, bus.ca_out, bus.cb_out}, '0);
                chk({nm, "_rst_text"}, bus.text_out, '0);
                chk({nm, "_rst_tag"}, bus.tag_out, '0);
                ndone = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (bus.done_out || bus.busy_out) ndone++;
                end
                chk({nm, "_rst_quiet"}, 128'(ndone), '0);
                exp_q.delete();
                return;
            end
            if (bus.done_out) begin
                done_seen = 1'b1;
                break;
            end
        end
        bus.start_in = 1'b0;
        bus.core_ready_in = 1'b1;
        chk({nm, "_done_seen"}, {127'd0, done_seen}, 128'd1);
        if (exp_lat >= 0) chk({nm, "_latency"}, 128'(cyc), 128'(exp_lat));
        chk({nm, "_steps"}, 128'(nst), 128'(exp_steps));
        chk({nm, "_left"}, 128'(exp_q.size()), '0);
        chk({nm, "_text"}, bus.text_out, et);
        chk({nm, "_tag"}, bus.tag_out, eg);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[6];
    req_t r, r2, r3;
    logic [127:0] ct, tg, ct2, tg2;

    initial begin
        tbl[0] = '{1'b1, 8'd0,   8'd0,   3073, 3072};
        tbl[1] = '{1'b1, 8'd128, 8'd128, 3329, 3328};
        tbl[2] = '{1'b1, 8'd200, 8'd5,   3206, 3205};
        tbl[3] = '{1'b0, 8'd64,  8'd100, 3237, 3236};
        tbl[4] = '{1'b1, 8'd255, 8'd255, 3329, 3328};
        tbl[5] = '{1'b1, 8'd1,   8'd1,   3075, 3074};

        rst = 1'b0;
        bus.start_in = 1'b1; bus.encrypt_in = 1'b1; bus.key_in = '0; bus.iv_in = '0;
        bus.ad_in = '0; bus.ad_len_in = '0; bus.text_in = '0; bus.text_len_in = '0;
        bus.core_ready_in = 1'b1;

        // reset held with start high
        repeat (3) begin
            @(posedge clk); #1;
            chk("reset_ctrl", {121'd0, bus.busy_out, bus.done_out, bus.step_en_out,
                bus.core_clear_out, bus.m_bit_out, bus.ca_out, bus.cb_out}, '0);
            chk("reset_text_tag", bus.text_out | bus.tag_out, '0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset_release_accept", {126'd0, bus.busy_out, bus.core_clear_out}, 128'd3);
        bus.start_in = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("reset_abort_idle", {127'd0, bus.busy_out}, '0);

        // table-driven runs
        for (int i = 0; i < 6; i++) begin
            r = mk_req(tbl[i].enc, tbl[i].adl, tbl[i].tl);
            if (i == 0) begin r.key = '0; r.iv = '0; end
            run_case($sformatf("tbl%0d", i), r, 0, tbl[i].lat, tbl[i].steps, -1, -1, ct, tg);
            post_done($sformatf("tbl%0d", i));
        end

        // encrypt then decrypt the ciphertext
        r2 = mk_req(1'b1, 8'd128, 8'd128);
        run_case("enc128", r2, 0, 3329, 3328, -1, -1, ct, tg);
        post_done("enc128");
        r3 = r2; r3.enc = 1'b0; r3.text = ct;
        run_case("dec128", r3, 0, 3329, 3328, -1, -1, ct2, tg2);
        chk("dec128_plain", bus.text_out, r2.text);
        chk("dec128_same_tag", bus.tag_out, tg);
        post_done("dec128");

        // same encryption with random core stalls
        run_case("stall", r2, 30, -1, 3328, -1, -1, ct2, tg2);
        chk("stall_same_tag", bus.tag_out, tg);
        chk("stall_same_text", bus.text_out, ct);
        post_done("stall");

        // start pulsed mid-FINAL is ignored
        r = mk_req(1'b1, 8'd0, 8'd0);
        run_case("midfinal", r, 0, 3073, 3072, 2500, -1, ct, tg);
        post_done("midfinal");

        // start in the DONE cycle ignored, accepted the cycle after
        r = mk_req(1'b1, 8'd0, 8'd0);
        run_case("donestart", r, 0, 3073, 3072, -1, -1, ct, tg);
        bus.start_in = 1'b1;
        @(posedge clk); #1;
        chk("donestart_ignored", {126'd0, bus.busy_out, bus.core_clear_out}, '0);
        // this run is accepted on the next edge, then reset mid-TEXT
        r = mk_req(1'b1, 8'd0, 8'd128);
        run_case("rsttext", r, 0, -1, 0, -1, 2100, ct, tg);

        // recovery after the abort
        r = mk_req(1'b1, 8'd128, 8'd50);
        run_case("recover", r, 0, 3251, 3250, -1, -1, ct, tg);
        post_done("recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
